// File: rtl/sdram_bus_arbiter_if.sv
// rtl/sdram_bus_arbiter_if.sv - requester and SDRAM bus signals shared by the arbiter and its neighbours
interface sdram_bus_arbiter_if;
    logic        IReq;
    logic [31:0] IAddr;
    logic        IGrant;
    logic        IDone;
    logic        DReq;
    logic        DRW;
    logic [31:0] DAddr;
    logic        DGrant;
    logic        DDone;
    logic        MStrobe;
    logic        MRW;
    logic [31:0] MAddress;
    logic        MOwner;
    logic        MAck;
    logic        BusError;

    modport master (
        input  IReq, IAddr, DReq, DRW, DAddr, MAck,
        output IGrant, IDone, DGrant, DDone, MStrobe, MRW, MAddress, MOwner, BusError
    );

    modport slave (
        output IReq, IAddr, DReq, DRW, DAddr, MAck,
        input  IGrant, IDone, DGrant, DDone, MStrobe, MRW, MAddress, MOwner, BusError
    );
endinterface

// File: rtl/sdram_bus_arbiter.sv
// rtl/sdram_bus_arbiter.sv - I/D cache arbiter for the SDRAM bus with burst counting and watchdog abort
module sdram_bus_arbiter #(
    parameter int BURST_LEN  = 4,
    parameter bit D_PRIORITY = 1'b0,
    parameter int TIMEOUT    = 255
) (
    input logic                 Clk,
    input logic                 Reset,
    sdram_bus_arbiter_if.master bus
);
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [BW-1:0] BEAT_ONE   = BW'(1);
    localparam logic [BW-1:0] LAST_BEAT  = BW'(BURST_LEN);
    localparam logic [WW-1:0] WDOG_ONE   = WW'(1);
    localparam logic [WW-1:0] WDOG_LIMIT = WW'(TIMEOUT - 1);
    localparam logic [31:0]   ADDR_MASK  = ~(32'(BURST_LEN) - 32'd1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_XFER, S_DONE, S_ABORT} state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          mrw_q, mrw_d;
    logic [31:0]   maddr_q, maddr_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          rr_q, rr_d;
    logic          winner;
    logic [BW-1:0] beat_inc;
    logic [31:0]   win_addr;
    logic          granted;
    logic          done_pulse;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            mrw_q   <= 1'b1;
            maddr_q <= '0;
            beat_q  <= '0;
            wdog_q  <= '0;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            mrw_q   <= mrw_d;
            maddr_q <= maddr_d;
            beat_q  <= beat_d;
            wdog_q  <= wdog_d;
            rr_q    <= rr_d;
        end
    end

    // rr_q set means the D-side is favoured on the next tie
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        mrw_d    = mrw_q;
        maddr_d  = maddr_q;
        beat_d   = beat_q;
        wdog_d   = wdog_q;
        rr_d     = rr_q;
        winner   = bus.DReq & (~bus.IReq | D_PRIORITY | rr_q);
        beat_inc = beat_q + BEAT_ONE;
        win_addr = winner ? bus.DAddr : bus.IAddr;
        unique case (state_q)
            S_IDLE: begin
                if (bus.IReq || bus.DReq) begin
                    state_d = S_ISSUE;
                    owner_d = winner;
                    mrw_d   = winner ? bus.DRW : 1'b1;
                    maddr_d = {1'b0, win_addr[31:1]} & ADDR_MASK;
                    beat_d  = '0;
                    wdog_d  = '0;
                end
            end
            S_ISSUE, S_XFER: begin
                if (bus.MAck) begin
                    beat_d  = beat_inc;
                    wdog_d  = '0;
                    state_d = (beat_inc == LAST_BEAT) ? S_DONE : S_XFER;
                end else begin
                    wdog_d = wdog_q + WDOG_ONE;
                    if (wdog_q == WDOG_LIMIT) begin
                        state_d = S_ABORT;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                rr_d    = ~owner_q;
                beat_d  = '0;
                wdog_d  = '0;
            end
            S_ABORT: begin
                state_d = S_IDLE;
                beat_d  = '0;
                wdog_d  = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        granted      = 1'b0;
        done_pulse   = 1'b0;
        bus.MStrobe  = 1'b0;
        bus.BusError = 1'b0;
        case (state_q)
            S_ISSUE: begin
                granted     = 1'b1;
                bus.MStrobe = 1'b1;
            end
            S_XFER:  granted = 1'b1;
            S_DONE: begin
                granted    = 1'b1;
                done_pulse = 1'b1;
            end
            S_ABORT: begin
                granted      = 1'b1;
                done_pulse   = 1'b1;
                bus.BusError = 1'b1;
            end
            default: ;
        endcase
        bus.IGrant   = granted & ~owner_q;
        bus.DGrant   = granted & owner_q;
        bus.IDone    = done_pulse & ~owner_q;
        bus.DDone    = done_pulse & owner_q;
        bus.MRW      = mrw_q;
        bus.MAddress = maddr_q;
        bus.MOwner   = owner_q;
    end
endmodule
